// File: rtl/lsu_pkg.sv
// Shared address map, access-size encoding and lane helpers for the LSU.
package lsu_pkg;

  // Data memory base; its upper limit depends on the configured depth.
  localparam logic [31:0] DMEM_BASE = 32'h0000_2000;

  // Memory-mapped I/O windows (inclusive byte ranges).
  localparam logic [31:0] LEDR_BASE = 32'h0000_7000;
  localparam logic [31:0] LEDR_LAST = 32'h0000_7003;
  localparam logic [31:0] LEDG_BASE = 32'h0000_7010;
  localparam logic [31:0] LEDG_LAST = 32'h0000_7013;
  localparam logic [31:0] HEX_BASE  = 32'h0000_7020;
  localparam logic [31:0] HEX_LAST  = 32'h0000_7023;
  localparam logic [31:0] SW_BASE   = 32'h0000_7800;
  localparam logic [31:0] SW_LAST   = 32'h0000_7803;

  // Access size; encoding 2'b11 is handled as a word access by the decoder.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  // Inclusive full-width address range compare.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // Replace the enabled byte lanes of a register with new data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) res[8*l +: 8] = new_val[8*l +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-enabled data memory: synchronous write, asynchronous read, no reset.
module lsu_dmem #(
  parameter int WORDS = 512,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_q [WORDS];

  // Write only the enabled lanes of the addressed word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < 4; l++) begin
        if (i_be[l]) mem_q[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
      end
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit: address decode, lane shifting, load extension, LED/HEX
// output registers and the switch synchronizer around the data memory.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_unsigned,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex
);

  localparam int          AW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_LAST = DMEM_BASE + 32'(4 * DMEM_WORDS) - 32'd1;

  logic        sz_byte, sz_half, sz_word;
  logic        misaligned;
  logic        hit_dmem, hit_ledr, hit_ledg, hit_hex, hit_sw;
  logic        st_ok;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] dmem_rdata;
  logic [31:0] rword;
  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  logic [31:0] ledr_q, ledr_d;
  logic [31:0] ledg_q, ledg_d;
  logic [31:0] hex_q,  hex_d;
  logic [31:0] sw_meta_q, sw_sync_q;

  assign hit_dmem = in_range(i_lsu_addr, DMEM_BASE, DMEM_LAST);
  assign hit_ledr = in_range(i_lsu_addr, LEDR_BASE, LEDR_LAST);
  assign hit_ledg = in_range(i_lsu_addr, LEDG_BASE, LEDG_LAST);
  assign hit_hex  = in_range(i_lsu_addr, HEX_BASE,  HEX_LAST);
  assign hit_sw   = in_range(i_lsu_addr, SW_BASE,   SW_LAST);

  // Size decode, alignment check, byte enables and lane-replicated store data.
  always_comb begin
    sz_byte = (i_lsu_size == SZ_BYTE);
    sz_half = (i_lsu_size == SZ_HALF);
    sz_word = !(sz_byte || sz_half);
    misaligned = (sz_half && i_lsu_addr[0]) ||
                 (sz_word && (i_lsu_addr[1:0] != 2'b00));
    be    = 4'b1111;
    wdata = i_st_data;
    if (sz_byte) begin
      be    = 4'b0001 << i_lsu_addr[1:0];
      wdata = {4{i_st_data[7:0]}};
    end else if (sz_half) begin
      be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{i_st_data[15:0]}};
    end
  end

  // Stores are suppressed on misalignment and while reset is held.
  assign st_ok = i_lsu_wren && !misaligned && i_rst_n;

  lsu_dmem #(
    .WORDS (DMEM_WORDS)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_we    (st_ok && hit_dmem),
    .i_be    (be),
    .i_addr  (i_lsu_addr[2 +: AW]),
    .i_wdata (wdata),
    .o_rdata (dmem_rdata)
  );

  // Next-state for the partially writable I/O output registers.
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    hex_d  = hex_q;
    if (st_ok && hit_ledr) ledr_d = merge_lanes(ledr_q, wdata, be);
    if (st_ok && hit_ledg) ledg_d = merge_lanes(ledg_q, wdata, be);
    if (st_ok && hit_hex)  hex_d  = merge_lanes(hex_q,  wdata, be);
  end

  // I/O output registers clear asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= '0;
    end else begin
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      hex_q  <= hex_d;
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Read-word select, lane shift down to bit 0, then sign/zero extension.
  always_comb begin
    rword = '0;
    if (hit_dmem)      rword = dmem_rdata;
    else if (hit_ledr) rword = ledr_q;
    else if (hit_ledg) rword = ledg_q;
    else if (hit_hex)  rword = hex_q;
    else if (hit_sw)   rword = sw_sync_q;

    shamt = 5'd0;
    if (sz_byte)      shamt = {i_lsu_addr[1:0], 3'b000};
    else if (sz_half) shamt = {i_lsu_addr[1], 4'b0000};
    lane = rword >> shamt;

    ld_ext = rword;
    if (sz_byte) begin
      ld_ext = i_lsu_unsigned ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
    end else if (sz_half) begin
      ld_ext = i_lsu_unsigned ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
    end
  end

  assign o_ld_data    = misaligned ? 32'd0 : ld_ext;
  assign o_misaligned = misaligned;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_hex     = hex_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio using a byte-addressed reference model.
module tb_lsu_mmio;

  localparam int DMEM_WORDS = 512;
  localparam int DMEM_BYTES = 4 * DMEM_WORDS;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic [1:0]  i_lsu_size;
  logic        i_lsu_unsigned;
  logic [31:0] i_io_sw;
  logic [31:0] o_ld_data;
  logic        o_misaligned;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;
  logic [31:0] o_io_hex;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: memory as bytes, I/O registers as words.
  logic [7:0]  m_dm [DMEM_BYTES];
  logic [31:0] m_ledr, m_ledg, m_hex, m_sw1, m_sw2;

  lsu_mmio #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_lsu_addr     (i_lsu_addr),
    .i_st_data      (i_st_data),
    .i_lsu_wren     (i_lsu_wren),
    .i_lsu_size     (i_lsu_size),
    .i_lsu_unsigned (i_lsu_unsigned),
    .i_io_sw        (i_io_sw),
    .o_ld_data      (o_ld_data),
    .o_misaligned   (o_misaligned),
    .o_io_ledr      (o_io_ledr),
    .o_io_ledg      (o_io_ledg),
    .o_io_hex       (o_io_hex)
  );

  always #5 i_clk = ~i_clk;

  function automatic int m_nbytes(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [31:0] a, input logic [1:0] size);
    return (a % m_nbytes(size)) != 0;
  endfunction

  function automatic logic [7:0] m_byte(input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (a >= 32'h2000 && a < 32'h2000 + DMEM_BYTES) return m_dm[int'(a - 32'h2000)];
    if (a >= 32'h7000 && a <= 32'h7003) return m_ledr[8*off +: 8];
    if (a >= 32'h7010 && a <= 32'h7013) return m_ledg[8*off +: 8];
    if (a >= 32'h7020 && a <= 32'h7023) return m_hex[8*off +: 8];
    if (a >= 32'h7800 && a <= 32'h7803) return m_sw2[8*off +: 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] size,
                                         input logic uns);
    logic [31:0] v;
    int n;
    n = m_nbytes(size);
    if (m_mis(a, size)) return 32'd0;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(m_byte(a + 32'(i))) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic m_set_byte(input logic [31:0] a, input logic [7:0] b);
    int off;
    off = int'(a % 4);
    if (a >= 32'h2000 && a < 32'h2000 + DMEM_BYTES) m_dm[int'(a - 32'h2000)] = b;
    else if (a >= 32'h7000 && a <= 32'h7003) m_ledr[8*off +: 8] = b;
    else if (a >= 32'h7010 && a <= 32'h7013) m_ledg[8*off +: 8] = b;
    else if (a >= 32'h7020 && a <= 32'h7023) m_hex[8*off +: 8] = b;
  endtask

  task automatic m_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
    if (!i_rst_n || m_mis(a, size)) return;
    for (int i = 0; i < m_nbytes(size); i++) m_set_byte(a + 32'(i), d[8*i +: 8]);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] size, input logic uns,
                       input logic wren, input logic [31:0] d);
    i_lsu_addr     = a;
    i_lsu_size     = size;
    i_lsu_unsigned = uns;
    i_lsu_wren     = wren;
    i_st_data      = d;
    #1;
  endtask

  // Advance one clock edge, applying the model's view of that edge.
  task automatic tick();
    if (i_lsu_wren) m_store(i_lsu_addr, i_lsu_size, i_st_data);
    if (i_rst_n) begin
      m_sw2 = m_sw1;
      m_sw1 = i_io_sw;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_io_sw = 32'd0;
    m_ledr = 0; m_ledg = 0; m_hex = 0; m_sw1 = 0; m_sw2 = 0;
    drive(32'h7000, 2'b10, 1'b0, 1'b1, 32'h1234_5678);
    #2;
    total_cnt++;
    if ({o_io_ledr, o_io_ledg, o_io_hex} !== 96'd0) $display("FAIL reset_io got %h %h %h want 0", o_io_ledr, o_io_ledg, o_io_hex);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (o_io_ledr !== 32'd0) $display("FAIL reset_store_ignored got %h want 0", o_io_ledr);
    else pass_cnt++;
    drive(32'h7800, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'd0) $display("FAIL reset_sw_read got %h want 0", o_ld_data);
    else pass_cnt++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_dmem();
    for (int w = 0; w < DMEM_WORDS; w++) begin
      drive(32'h2000 + 32'(4 * w), 2'b10, 1'b0, 1'b1, $urandom);
      tick();
    end
    drive(32'h2000, 2'b10, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_word_and_partial();
    drive(32'h2004, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF); tick();
    drive(32'h2004, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'hDEAD_BEEF) $display("FAIL lw_2004 got %h want DEADBEEF", o_ld_data); else pass_cnt++;
    drive(32'h2007, 2'b00, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'hFFFF_FFDE) $display("FAIL lb_2007 got %h want FFFFFFDE", o_ld_data); else pass_cnt++;
    drive(32'h2007, 2'b00, 1'b1, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'h0000_00DE) $display("FAIL lbu_2007 got %h want 000000DE", o_ld_data); else pass_cnt++;
    drive(32'h2004, 2'b01, 1'b1, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'h0000_BEEF) $display("FAIL lhu_2004 got %h want 0000BEEF", o_ld_data); else pass_cnt++;
    drive(32'h2005, 2'b00, 1'b0, 1'b1, 32'h0000_0012); tick();
    drive(32'h2004, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'hDEAD_12EF) $display("FAIL sb_2005 got %h want DEAD12EF", o_ld_data); else pass_cnt++;
    drive(32'h2006, 2'b01, 1'b0, 1'b1, 32'h0000_5678); tick();
    drive(32'h2004, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'h5678_12EF) $display("FAIL sh_2006 got %h want 567812EF", o_ld_data); else pass_cnt++;
  endtask

  task automatic test_misalign();
    drive(32'h2002, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF);
    total_cnt++;
    if (o_misaligned !== 1'b1 || o_ld_data !== 32'd0) $display("FAIL mis_lw_2002 got mis=%b ld=%h want 1/0", o_misaligned, o_ld_data); else pass_cnt++;
    tick();
    drive(32'h2003, 2'b01, 1'b0, 1'b1, 32'h0000_AAAA);
    total_cnt++;
    if (o_misaligned !== 1'b1) $display("FAIL mis_sh_2003 got %b want 1", o_misaligned); else pass_cnt++;
    tick();
    drive(32'h7001, 2'b01, 1'b0, 1'b1, 32'h0000_5555); tick();
    drive(32'h2004, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'h5678_12EF || o_misaligned !== 1'b0) $display("FAIL mis_no_write got %h mis=%b want 567812EF/0", o_ld_data, o_misaligned); else pass_cnt++;
    total_cnt++;
    if (o_io_ledr !== 32'd0) $display("FAIL mis_io_no_write got %h want 0", o_io_ledr); else pass_cnt++;
  endtask

  task automatic test_io();
    drive(32'h7000, 2'b10, 1'b0, 1'b1, 32'h0000_00AA); tick();
    total_cnt++;
    if (o_io_ledr !== 32'h0000_00AA) $display("FAIL ledr_sw got %h want 000000AA", o_io_ledr); else pass_cnt++;
    drive(32'h7011, 2'b00, 1'b0, 1'b1, 32'h0000_005A); tick();
    drive(32'h7022, 2'b01, 1'b0, 1'b1, 32'h0000_BEEF); tick();
    total_cnt++;
    if (o_io_ledg !== 32'h0000_5A00 || o_io_hex !== 32'hBEEF_0000) $display("FAIL io_partial got ledg=%h hex=%h want 00005A00/BEEF0000", o_io_ledg, o_io_hex); else pass_cnt++;
    drive(32'h7022, 2'b01, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'hFFFF_BEEF) $display("FAIL lh_hex got %h want FFFFBEEF", o_ld_data); else pass_cnt++;
    // Mid-cycle asynchronous reset.
    #2;
    i_rst_n = 1'b0;
    m_ledr = 0; m_ledg = 0; m_hex = 0; m_sw1 = 0; m_sw2 = 0;
    #1;
    total_cnt++;
    if ({o_io_ledr, o_io_ledg, o_io_hex} !== 96'd0) $display("FAIL async_reset got %h %h %h want 0", o_io_ledr, o_io_ledg, o_io_hex); else pass_cnt++;
    drive(32'h2004, 2'b10, 1'b0, 1'b1, 32'h0BAD_0BAD);
    total_cnt++;
    if (o_ld_data !== 32'h5678_12EF) $display("FAIL dmem_kept_in_reset got %h want 567812EF", o_ld_data); else pass_cnt++;
    tick();
    total_cnt++;
    if (o_ld_data !== 32'h5678_12EF) $display("FAIL dmem_store_in_reset got %h want 567812EF", o_ld_data); else pass_cnt++;
    #2;
    i_rst_n = 1'b1;
    drive(32'h2004, 2'b10, 1'b0, 1'b1, 32'h1122_3344); tick();
    drive(32'h2004, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'h1122_3344) $display("FAIL first_store_after_reset got %h want 11223344", o_ld_data); else pass_cnt++;
  endtask

  task automatic test_sw_sync();
    i_io_sw = 32'h0000_03C0;
    drive(32'h7800, 2'b10, 1'b0, 1'b0, 32'd0);
    tick();
    total_cnt++;
    if (o_ld_data !== 32'd0) $display("FAIL sw_one_edge got %h want 0", o_ld_data); else pass_cnt++;
    tick();
    total_cnt++;
    if (o_ld_data !== 32'h0000_03C0) $display("FAIL sw_two_edges got %h want 000003C0", o_ld_data); else pass_cnt++;
    drive(32'h7800, 2'b10, 1'b0, 1'b1, 32'h0000_0000); tick();
    drive(32'h7800, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'h0000_03C0) $display("FAIL sw_readonly got %h want 000003C0", o_ld_data); else pass_cnt++;
  endtask

  task automatic test_unmapped();
    logic [31:0] w0;
    drive(32'h1000, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF);
    total_cnt++;
    if (o_ld_data !== 32'd0) $display("FAIL lw_1000 got %h want 0", o_ld_data); else pass_cnt++;
    tick();
    total_cnt++;
    if (o_io_ledr !== m_ledr || o_io_ledg !== m_ledg || o_io_hex !== m_hex) $display("FAIL sw_1000_io got %h %h %h want %h %h %h", o_io_ledr, o_io_ledg, o_io_hex, m_ledr, m_ledg, m_hex); else pass_cnt++;
    drive(32'h27FC, 2'b10, 1'b0, 1'b1, 32'hCAFE_F00D); tick();
    drive(32'h27FC, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'hCAFE_F00D) $display("FAIL last_word got %h want CAFEF00D", o_ld_data); else pass_cnt++;
    w0 = m_load(32'h2000, 2'b10, 1'b0);
    drive(32'h2800, 2'b10, 1'b0, 1'b1, ~w0); tick();
    drive(32'h2800, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== 32'd0) $display("FAIL lw_2800 got %h want 0", o_ld_data); else pass_cnt++;
    drive(32'h2000, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== w0) $display("FAIL no_alias_2800 got %h want %h", o_ld_data, w0); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] old_v;
    old_v = m_load(32'h2008, 2'b10, 1'b0);
    drive(32'h2008, 2'b10, 1'b0, 1'b1, ~old_v);
    total_cnt++;
    if (o_ld_data !== old_v) $display("FAIL same_cycle_old got %h want %h", o_ld_data, old_v); else pass_cnt++;
    tick();
    drive(32'h2008, 2'b10, 1'b0, 1'b0, 32'd0);
    total_cnt++;
    if (o_ld_data !== ~old_v) $display("FAIL same_cycle_new got %h want %h", o_ld_data, ~old_v); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a, exp_ld;
    logic [1:0]  sz;
    logic        uns;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 7))
        0, 1: a = 32'h2000 + 32'($urandom_range(0, DMEM_BYTES - 1));
        2:    a = 32'h7000 + 32'($urandom_range(0, 3));
        3:    a = 32'h7010 + 32'($urandom_range(0, 3));
        4:    a = 32'h7020 + 32'($urandom_range(0, 3));
        5:    a = 32'h7800 + 32'($urandom_range(0, 3));
        6:    a = $urandom;
        default: begin
          case ($urandom_range(0, 4))
            0: a = 32'h1FFF;
            1: a = 32'h2800;
            2: a = 32'h27FF;
            3: a = 32'h7004;
            default: a = 32'h6FFF;
          endcase
        end
      endcase
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) i_io_sw = $urandom;
      drive(a, sz, uns, 1'($urandom_range(0, 1)), $urandom);
      exp_ld = m_load(a, sz, uns);
      total_cnt++;
      if (o_ld_data !== exp_ld || o_misaligned !== 1'(m_mis(a, sz)))
        $display("FAIL rand_load a=%h sz=%0d u=%b got %h/%b want %h/%b", a, sz, uns, o_ld_data, o_misaligned, exp_ld, m_mis(a, sz));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (o_io_ledr !== m_ledr || o_io_ledg !== m_ledg || o_io_hex !== m_hex)
        $display("FAIL rand_io got %h %h %h want %h %h %h", o_io_ledr, o_io_ledg, o_io_hex, m_ledr, m_ledg, m_hex);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    fill_dmem();
    test_word_and_partial();
    test_misalign();
    test_io();
    test_sw_sync();
    test_unmapped();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Load/store unit for the single-cycle core. Consumes the 32-bit ALU sum as the effective address, performs byte/half/word loads and stores against an internal byte-enabled data memory and a small memory-mapped I/O region, and returns sign- or zero-extended load data to the writeback mux. Loads are combinational within the instruction's cycle. Stores, I/O output registers and the switch synchronizer are clocked.

## Interface
- DMEM_WORDS, 512, data memory depth in 32-bit words (2 KiB); power of two.
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_lsu_addr  in  32  effective address (ALU result).
- i_st_data  in  32  store data (rs2); the low bytes are used for byte and half stores.
- i_lsu_wren  in  1  store enable for this cycle.
- i_lsu_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- i_lsu_unsigned  in  1  1 = zero-extend loads (LBU/LHU); 0 = sign-extend.
- i_io_sw  in  32  asynchronous switch inputs.
- o_ld_data  out  32  extended load data; combinational.
- o_misaligned  out  1  access violates natural alignment; combinational.
- o_io_ledr  out  32  red LED register.
- o_io_ledg  out  32  green LED register.
- o_io_hex  out  32  seven-segment register (8 nibbles).

## Operation
- Address map (byte addresses, full 32-bit compare):
  - DMEM: 0x0000_2000–0x0000_2000+4·DMEM_WORDS−1, word index = addr[2+:log2(DMEM_WORDS)].
  - LEDR: 0x0000_7000–7003.
  - LEDG: 0x0000_7010–7013.
  - HEX: 0x0000_7020–7023.
  - SW: 0x0000_7800–7803, read-only.
- Unmapped region: loads return 0; stores are dropped.
- Byte lane select: addr[1:0].
  - Byte access: lane addr[1:0].
  - Half access: lanes {addr[1],0}+1..+0.
  - Word access: all four lanes.
- Store: on the rising edge, write only the selected lanes of the target word. Store data is lane-shifted: byte → st_data[7:0] replicated to all lanes; half → st_data[15:0] replicated to both halves.
- Load: select the target word, shift the addressed lanes down to bit 0, then extend to 32 bits per i_lsu_unsigned. Word loads ignore i_lsu_unsigned.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - o_misaligned=1.
  - Store suppressed in every region.
  - o_ld_data=0.
- SW path: two-flop synchronizer. Loads read the second flop.
- I/O output registers accept partial (byte/half) stores exactly like DMEM.

## Timing
- Load: zero latency. o_ld_data reflects register/memory contents as they stand before the current edge.
- Store: visible to loads from the cycle after the edge.
- Load and store to the same address in one cycle: the load returns the old value.
- SW: a change on i_io_sw is readable on the second rising edge after it is applied.
- Reset (asserted, asynchronous):
  - o_io_ledr, o_io_ledg, o_io_hex and both SW flops go to 0 immediately.
  - DMEM contents are not reset.
  - While i_rst_n=0, all stores are ignored, DMEM included.
- Reset deassertion: the first store takes effect on the first rising edge with i_rst_n=1.
- o_ld_data and o_misaligned are combinational and are valid during reset.

## Structure
- Package lsu_pkg holds:
  - the base/limit constants for DMEM, LEDR, LEDG, HEX and SW;
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module lsu_dmem: DMEM_WORDS×32 array, 4-bit byte enable, synchronous write, asynchronous read, no reset.
- lsu_mmio contains:
  - address decode;
  - lane shift and extension logic;
  - I/O registers;
  - the SW synchronizer.

## Test plan
- SW to 0x2004 with st_data=0xDEADBEEF; next cycle LW 0x2004 → 0xDEADBEEF; LB 0x2007 → 0xFFFFFFDE; LBU 0x2007 → 0x000000DE; LHU 0x2004 → 0x0000BEEF.
- SB 0x2005 with st_data=0x12, word previously 0xDEADBEEF; LW 0x2004 → 0xDEAD12EF. SH 0x2006 with st_data=0x5678 → 0x567812EF.
- Misalignment: LW 0x2002 → o_misaligned=1, o_ld_data=0, no change in memory. SH 0x2003 → o_misaligned=1, word unchanged.
- I/O: SW 0x7000 with 0x000000AA → o_io_ledr=0xAA on the next edge. Assert i_rst_n=0 mid-cycle → o_io_ledr=0 immediately, while DMEM at 0x2004 still reads its prior value.
- Switch synchronizer: i_io_sw=0x3C0 → LW 0x7800 reads 0 after 1 edge and 0x3C0 after 2 edges. SW 0x7800 is ignored.
- Unmapped and boundary accesses:
  - LW 0x1000 → 0; SW 0x1000 leaves all state unchanged.
  - LW 0x27FC (last DMEM word) is stored and read correctly.
  - 0x2800 is unmapped.
- Same-cycle load and store to 0x2008: the load returns the old value and the new value appears the following cycle.
